// File: rtl/sd_spi_master.sv
// SPI mode-0 byte master for SD cards in SPI mode, one byte per request.
// Optional fast mode (SCK = clk_i/2) is compiled in with SD_SPI_MASTER_FAST_EN;
// without it func_i has no effect and every transfer uses the slow half-period.
module sd_spi_master #(
   parameter int unsigned REF_CLK  = 10000000,
   parameter int unsigned BAUDRATE = 400000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ce_i,
   input  logic       we_i,
   input  logic       func_i,
   input  logic [7:0] data_i,
   input  logic       sd_di_i,
   output logic [7:0] data_o,
   output logic       val_o,
   output logic       sd_clk_o,
   output logic       sd_do_o
);

   // Slow half-period rounded up so SCK never exceeds BAUDRATE.
   localparam int unsigned HALF_RAW = (REF_CLK + 2 * BAUDRATE - 1) / (2 * BAUDRATE);
   localparam int unsigned HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
   localparam int unsigned CNT_W    = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       tx_q, tx_d;
   logic [7:0]       rx_q, rx_d;
   logic [7:0]       data_q, data_d;
   logic             val_q, val_d;
   logic             sck_q, sck_d;
   logic             do_q, do_d;
   logic             fast_q, fast_d;
   logic             half_done_c;

`ifdef SD_SPI_MASTER_FAST_EN
   // Fast transfers toggle SCK on every clk_i edge.
   assign half_done_c = fast_q | (cnt_q == CNT_LAST);
`else
   logic func_unused;
   assign func_unused = func_i;
   assign half_done_c = (cnt_q == CNT_LAST);
`endif

   // Next-state and datapath: accept in IDLE, toggle SCK every half-period in SHIFT.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      data_d  = data_q;
      val_d   = 1'b0;
      sck_d   = sck_q;
      do_d    = do_q;
      fast_d  = fast_q;
      case (state_q)
         ST_IDLE: begin
            sck_d = 1'b0;
            do_d  = 1'b1;
            if (ce_i) begin
               state_d = ST_SHIFT;
               tx_d    = we_i ? data_i : 8'hFF;
               do_d    = tx_d[7];
               cnt_d   = '0;
               bit_d   = 3'd0;
               rx_d    = 8'h00;
`ifdef SD_SPI_MASTER_FAST_EN
               fast_d  = func_i;
`else
               fast_d  = 1'b0;
`endif
            end
         end
         ST_SHIFT: begin
            if (half_done_c) begin
               cnt_d = '0;
               if (!sck_q) begin
                  sck_d = 1'b1;
                  rx_d  = {rx_q[6:0], sd_di_i};
               end else begin
                  sck_d = 1'b0;
                  if (bit_q == 3'd7) begin
                     state_d = ST_IDLE;
                     data_d  = rx_q;
                     val_d   = 1'b1;
                     do_d    = 1'b1;
                  end else begin
                     bit_d = bit_q + 3'd1;
                     tx_d  = {tx_q[6:0], 1'b0};
                     do_d  = tx_q[6];
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         tx_q    <= 8'h00;
         rx_q    <= 8'h00;
         data_q  <= 8'h00;
         val_q   <= 1'b0;
         sck_q   <= 1'b0;
         do_q    <= 1'b1;
         fast_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         data_q  <= data_d;
         val_q   <= val_d;
         sck_q   <= sck_d;
         do_q    <= do_d;
         fast_q  <= fast_d;
      end
   end

   assign data_o   = data_q;
   assign val_o    = val_q;
   assign sd_clk_o = sck_q;
   assign sd_do_o  = do_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master at default parameters (H = 13).
module tb_sd_spi_master;

   logic       clk_i;
   logic       rst_i;
   logic       ce_i;
   logic       we_i;
   logic       func_i;
   logic [7:0] data_i;
   logic       sd_di_i;
   logic [7:0] data_o;
   logic       val_o;
   logic       sd_clk_o;
   logic       sd_do_o;

   logic       loop_en;
   logic       fixed_di;

   int unsigned n_checks;
   int unsigned n_fail;

   // SCK monitor state
   logic        mon_clr;
   logic        prev_sck;
   logic [7:0]  mosi_bits;
   int unsigned rise_cnt;
   int unsigned hi_len;
   int unsigned hi_min;
   int unsigned hi_max;
   int unsigned val_cnt;

   int lat;

   sd_spi_master dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .ce_i     (ce_i),
      .we_i     (we_i),
      .func_i   (func_i),
      .data_i   (data_i),
      .sd_di_i  (sd_di_i),
      .data_o   (data_o),
      .val_o    (val_o),
      .sd_clk_o (sd_clk_o),
      .sd_do_o  (sd_do_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   assign sd_di_i = loop_en ? sd_do_o : fixed_di;

   // Records MOSI at each SCK rise, SCK high widths and val_o pulses.
   always @(negedge clk_i) begin
      if (mon_clr) begin
         mosi_bits = 8'h00;
         rise_cnt  = 0;
         hi_len    = 0;
         hi_min    = 9999;
         hi_max    = 0;
         val_cnt   = 0;
      end else begin
         if (sd_clk_o && !prev_sck) begin
            mosi_bits = {mosi_bits[6:0], sd_do_o};
            rise_cnt++;
            hi_len = 1;
         end else if (sd_clk_o) begin
            hi_len++;
         end
         if (!sd_clk_o && prev_sck) begin
            if (hi_len < hi_min) hi_min = hi_len;
            if (hi_len > hi_max) hi_max = hi_len;
         end
         if (val_o) val_cnt++;
      end
      prev_sck = sd_clk_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One request; lat = clk_i edges from acceptance to the edge that raises val_o.
   task automatic do_xfer(input logic we, input logic [7:0] d, input logic fn, output int l);
      @(posedge clk_i);
      #1 mon_clr = 1'b1;
      @(negedge clk_i);
      ce_i   = 1'b1;
      we_i   = we;
      data_i = d;
      func_i = fn;
      @(posedge clk_i);
      #1 mon_clr = 1'b0;
      @(negedge clk_i);
      ce_i   = 1'b0;
      data_i = 8'h00;
      l = 0;
      while (!val_o && l < 1000) begin
         @(negedge clk_i);
         l++;
      end
      @(negedge clk_i);
      check("val_single_cycle", {31'd0, val_o}, 32'd0);
   endtask

   initial begin
      int n;
      n_checks = 0;
      n_fail   = 0;
      mon_clr  = 1'b1;
      prev_sck = 1'b0;
      loop_en  = 1'b1;
      fixed_di = 1'b0;
      rst_i    = 1'b1;
      ce_i     = 1'b0;
      we_i     = 1'b0;
      func_i   = 1'b0;
      data_i   = 8'h00;

      // Reset state
      repeat (3) @(negedge clk_i);
      check("rst_sck",  {31'd0, sd_clk_o}, 32'd0);
      check("rst_mosi", {31'd0, sd_do_o},  32'd1);
      check("rst_val",  {31'd0, val_o},    32'd0);
      check("rst_data", {24'd0, data_o},   32'h00);
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);

      // Write A5 with loopback
      loop_en = 1'b1;
      do_xfer(1'b1, 8'hA5, 1'b0, lat);
      check("a5_latency", lat, 32'd208);
      check("a5_data",    {24'd0, data_o},    32'hA5);
      check("a5_mosi",    {24'd0, mosi_bits}, 32'hA5);
      check("a5_rises",   rise_cnt,           32'd8);
      check("a5_idle_mosi", {31'd0, sd_do_o},  32'd1);
      check("a5_idle_sck",  {31'd0, sd_clk_o}, 32'd0);

      // Read: MOSI all ones, MISO held low
      loop_en  = 1'b0;
      fixed_di = 1'b0;
      do_xfer(1'b0, 8'h3C, 1'b0, lat);
      check("rd_latency", lat, 32'd208);
      check("rd_data",    {24'd0, data_o},    32'h00);
      check("rd_mosi",    {24'd0, mosi_bits}, 32'hFF);
      check("rd_rises",   rise_cnt,           32'd8);
      check("rd_hi_min",  hi_min,             32'd13);
      check("rd_hi_max",  hi_max,             32'd13);
      check("rd_val_cnt", val_cnt,            32'd1);

      // Back-to-back with ce_i held high and data_i disturbed mid-transfer
      loop_en = 1'b1;
      @(posedge clk_i);
      #1 mon_clr = 1'b1;
      @(negedge clk_i);
      ce_i   = 1'b1;
      we_i   = 1'b1;
      func_i = 1'b0;
      data_i = 8'h81;
      @(posedge clk_i);
      #1 mon_clr = 1'b0;
      n = 0;
      while (!val_o && n < 1000) begin
         @(negedge clk_i);
         n++;
         if (n == 50)  data_i = 8'h7E;
         if (n == 100) data_i = 8'h81;
      end
      check("b2b_data0", {24'd0, data_o}, 32'h81);
      for (int p = 0; p < 2; p++) begin
         n = 0;
         do begin
            @(negedge clk_i);
            n++;
            if (n == 50)  data_i = 8'h7E;
            if (n == 100) data_i = 8'h81;
         end while (!val_o && n < 1000);
         check("b2b_interval", n, 32'd209);
         check("b2b_data",     {24'd0, data_o}, 32'h81);
      end
      ce_i = 1'b0;
      repeat (5) @(negedge clk_i);
      check("b2b_stop_sck",  {31'd0, sd_clk_o}, 32'd0);
      check("b2b_val_total", val_cnt, 32'd3);

      // Reset mid-transfer at cycle 100
      @(posedge clk_i);
      #1 mon_clr = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i  = 1'b0;
      ce_i   = 1'b1;
      we_i   = 1'b1;
      data_i = 8'h5A;
      @(posedge clk_i);
      #1 mon_clr = 1'b0;
      @(negedge clk_i);
      ce_i = 1'b0;
      repeat (99) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("abort_sck",  {31'd0, sd_clk_o}, 32'd0);
      check("abort_mosi", {31'd0, sd_do_o},  32'd1);
      check("abort_val",  {31'd0, val_o},    32'd0);
      check("abort_data", {24'd0, data_o},   32'h00);
      rst_i = 1'b0;
      repeat (300) @(negedge clk_i);
      check("abort_no_val",  val_cnt,         32'd0);
      check("abort_data_kept", {24'd0, data_o}, 32'h00);

      // Reset wins over ce_i in the same cycle
      @(posedge clk_i);
      #1 mon_clr = 1'b1;
      @(negedge clk_i);
      rst_i  = 1'b1;
      ce_i   = 1'b1;
      we_i   = 1'b1;
      data_i = 8'h00;
      @(posedge clk_i);
      #1 mon_clr = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      ce_i  = 1'b0;
      repeat (40) @(negedge clk_i);
      check("prec_no_rise", rise_cnt, 32'd0);
      check("prec_mosi",    {31'd0, sd_do_o}, 32'd1);

      // Fast-mode request
      loop_en = 1'b1;
      do_xfer(1'b1, 8'hC3, 1'b1, lat);
`ifdef SD_SPI_MASTER_FAST_EN
      check("fast_latency", lat, 32'd16);
`else
      check("fast_latency", lat, 32'd208);
`endif
      check("fast_data",  {24'd0, data_o},    32'hC3);
      check("fast_mosi",  {24'd0, mosi_bits}, 32'hC3);
      check("fast_rises", rise_cnt,           32'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
